// File: rtl/core_pkg.sv
// Shared core types and constants.
// Holds the divider op and state encodings.
package core_pkg;

  typedef enum logic [1:0] {
    DIV_OP  = 2'b00,
    DIVU_OP = 2'b01,
    REM_OP  = 2'b10,
    REMU_OP = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  localparam int DIV_ITERS = 32;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; special cases finish in one cycle.
module div_unit
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            div_unit_busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  div_state_e state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      rd_q, rd_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            sel_rem_q, sel_rem_d;

  logic            sgn, a_neg, b_neg;
  logic            div0, ovf;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   rem_sh, rem_nx;
  logic [XLEN+1:0] diff;
  logic            ge;
  logic [XLEN-1:0] dvd_nx, quot_fix, rem_fix;
  logic            unused_rem_msb;

  // Remainder stays below the divisor, so the top bit never feeds back.
  assign unused_rem_msb = rem_q[XLEN];

  always_comb begin
    sgn   = ~op[0];
    a_neg = sgn & rs1_val[XLEN-1];
    b_neg = sgn & rs2_val[XLEN-1];
    a_abs = a_neg ? (~rs1_val + 1'b1) : rs1_val;
    b_abs = b_neg ? (~rs2_val + 1'b1) : rs2_val;
    div0  = (rs2_val == '0);
    ovf   = sgn && (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                && (rs2_val == '1);
  end

  always_comb begin
    rem_sh   = {rem_q[XLEN-1:0], dvd_q[XLEN-1]};
    diff     = {1'b0, rem_sh} - {2'b00, dsr_q};
    ge       = ~diff[XLEN+1];
    rem_nx   = ge ? diff[XLEN:0] : rem_sh;
    dvd_nx   = {dvd_q[XLEN-2:0], ge};
    quot_fix = qneg_q ? (~dvd_nx + 1'b1) : dvd_nx;
    rem_fix  = rneg_q ? (~rem_nx[XLEN-1:0] + 1'b1)
                      : rem_nx[XLEN-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    res_d     = res_q;
    rd_d      = rd_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    sel_rem_d = sel_rem_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (start && !kill) begin
          rd_d      = rd_in;
          sel_rem_d = op[1];
          if (div0 || ovf) begin
            if (op[1])
              res_d = div0 ? rs1_val : '0;
            else
              res_d = div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}};
            state_d = DIV_DONE;
          end else begin
            dvd_d   = a_abs;
            dsr_d   = b_abs;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rem_d = rem_nx;
        dvd_d = dvd_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITERS - 1)) begin
          cnt_d   = '0;
          res_d   = sel_rem_q ? rem_fix : quot_fix;
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (kill) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      res_q     <= '0;
      rd_q      <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      res_q     <= res_d;
      rd_q      <= rd_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      sel_rem_q <= sel_rem_d;
    end
  end

  assign div_unit_busy = (state_q != DIV_IDLE);
  assign result_valid  = (state_q == DIV_DONE);
  assign result        = res_q;
  assign rd_out        = rd_q;

endmodule
